// File: rtl/nanci_pkg.sv
// Shared widths, request field positions and FSM encoding for the NANCI application port.
// Pure declarations: no logic, no latency, no flow control.
// Every width in the port derives from addr_width(N), so change it here only.
package nanci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_COMPUTE   = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_RESP = 3'd4
    } state_t;

    localparam int CNT_WIDTH = 14;

    // Node address width for the supported network sizes; anything else falls back to 2.
    function automatic int addr_width(input int n);
        case (n)
            1024:    return 10;
            256:     return 8;
            64:      return 6;
            16:      return 4;
            4:       return 2;
            default: return 2;
        endcase
    endfunction

    function automatic int width_of(input int n, input int dw);
        return addr_width(n) + dw;
    endfunction

    function automatic int pkt_width_of(input int n, input int dw);
        return addr_width(n) + width_of(n, dw) + 1;
    endfunction

    // Request layout: {write flag, dest addr, data}.
    function automatic int req_wr_bit(input int n, input int dw);
        return width_of(n, dw);
    endfunction

    function automatic int req_addr_lsb(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/nanci_fifo.sv
// Registered first-word-fall-through FIFO for outbound packets.
// Latency: a push is visible on dout/!empty the next cycle.
// Backpressure: full blocks push, pop is ignored when empty.
module nanci_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    // Masked while empty so the packet bus reads zero out of reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/nanci_app_port.sv
// Application-side NANCI port: runs compute iterations, issues requests, waits for read responses.
// Latency: 2 + max(compute_cycles,1) cycles per write iteration; packet on the wire one cycle after issue.
// Backpressure: a full outbound FIFO stalls the FSM in ISSUE; inbound responses cannot be stalled.
module nanci_app_port
    import nanci_pkg::*;
#(
    parameter  int N          = 1024,
    parameter  int I          = 0,
    parameter  int DATA_WIDTH = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int ADDR_WIDTH = addr_width(N),
    localparam int WIDTH      = width_of(N, DATA_WIDTH),
    localparam int PKT_WIDTH  = pkt_width_of(N, DATA_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 runnable,
    input  logic [WIDTH:0]       app_request,
    input  logic [13:0]          compute_cycles,
    output logic [WIDTH:0]       nanci_result,
    output logic                 net_out_valid,
    input  logic                 net_out_ready,
    output logic [PKT_WIDTH-1:0] net_out_pkt,
    input  logic                 net_in_valid,
    input  logic [WIDTH:0]       net_in_pkt,
    output logic                 err_stray
);

    localparam int                    WR_BIT = req_wr_bit(N, DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] SRC    = ADDR_WIDTH'(I);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 push;
    logic                 capture;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    assign runnable      = (state == ST_RUN);
    assign net_out_valid = ~fifo_empty;
    assign pop           = net_out_valid & net_out_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        push      = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A zero compute latency still costs one COMPUTE cycle.
                cnt_nxt   = (compute_cycles == '0) ? CNT_WIDTH'(1) : compute_cycles;
                state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (cnt <= CNT_WIDTH'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_ISSUE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!fifo_full) begin
                    push = 1'b1;
                    if (app_request[WR_BIT])
                        state_nxt = enable ? ST_RUN : ST_IDLE;
                    else
                        state_nxt = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (net_in_valid) begin
                    capture   = 1'b1;
                    state_nxt = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            nanci_result <= '0;
            err_stray    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) nanci_result <= net_in_pkt;
            // Responses outside WAIT_RESP are dropped but remembered until reset.
            if (net_in_valid && state != ST_WAIT_RESP) err_stray <= 1'b1;
        end
    end

    nanci_fifo #(
        .WIDTH (PKT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({SRC, app_request}),
        .pop   (pop),
        .dout  (net_out_pkt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_nanci_app_port.sv
// Self-checking bench for nanci_app_port (N=16, I=3, 32-bit data, 4-deep FIFO).
module tb_nanci_app_port;

    localparam int N  = 16;
    localparam int I  = 3;
    localparam int DW = 32;
    localparam int FD = 4;
    localparam int W  = 36;
    localparam int PW = 41;
    localparam logic [3:0] SRC = 4'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          runnable;
    logic [W:0]    app_request = '0;
    logic [13:0]   compute_cycles = '0;
    logic [W:0]    nanci_result;
    logic          net_out_valid;
    logic          net_out_ready = 1'b0;
    logic [PW-1:0] net_out_pkt;
    logic          net_in_valid = 1'b0;
    logic [W:0]    net_in_pkt = '0;
    logic          err_stray;

    nanci_app_port #(
        .N          (N),
        .I          (I),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .runnable       (runnable),
        .app_request    (app_request),
        .compute_cycles (compute_cycles),
        .nanci_result   (nanci_result),
        .net_out_valid  (net_out_valid),
        .net_out_ready  (net_out_ready),
        .net_out_pkt    (net_out_pkt),
        .net_in_valid   (net_in_valid),
        .net_in_pkt     (net_in_pkt),
        .err_stray      (err_stray)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            pulses[$];
    logic [PW-1:0] got[$];
    logic [PW-1:0] exp_q[$];
    int            auto_mode = 0;
    logic [W:0]    fixed_req = '0;
    logic [W:0]    last_result = '0;

    // One clock cycle as the application sees it: record pops and runnable pulses,
    // and hand a fresh request to the application on each pulse.
    task automatic tick();
        logic          pop_now;
        logic [PW-1:0] pkt_now;
        logic [W:0]    r;
        pop_now = net_out_valid && net_out_ready;
        pkt_now = net_out_pkt;
        @(negedge clk);
        cyc++;
        if (pop_now) got.push_back(pkt_now);
        if (runnable) begin
            pulses.push_back(cyc);
            if (auto_mode == 1) begin
                r = {1'b1, 4'($urandom), 32'($urandom)};
                app_request = r;
                exp_q.push_back({SRC, r});
            end else if (auto_mode == 2) begin
                app_request = fixed_req;
                exp_q.push_back({SRC, fixed_req});
            end
        end
    endtask

    task automatic flush();
        pulses.delete();
        got.delete();
        exp_q.delete();
    endtask

    task automatic check_pkts(input string name);
        int n;
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_pkt_count got %0d want %0d", name, got.size(), exp_q.size());
        end
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s_pkt[%0d] got %h want %h", name, k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic run_writes(input int cc, input int nit, input int mode, input string name);
        int n;
        int want;
        flush();
        compute_cycles = 14'(cc);
        auto_mode = mode;
        net_out_ready = 1'b1;
        app_request = (mode == 2) ? fixed_req : {1'b1, 4'($urandom), 32'($urandom)};
        enable = 1'b1;
        n = 0;
        while (pulses.size() < nit && n < 500) begin
            tick();
            n++;
        end
        enable = 1'b0;
        checks++;
        if (pulses.size() < nit) begin
            errors++;
            $display("FAIL %s_timeout pulses %0d want %0d", name, pulses.size(), nit);
        end
        repeat (30) tick();
        checks++;
        if (pulses.size() != nit) begin
            errors++;
            $display("FAIL %s_pulse_count got %0d want %0d", name, pulses.size(), nit);
        end
        want = 2 + ((cc == 0) ? 1 : cc);
        for (int k = 1; k < pulses.size(); k++) begin
            checks++;
            if (pulses[k] - pulses[k-1] != want) begin
                errors++;
                $display("FAIL %s_interval[%0d] got %0d want %0d", name, k, pulses[k] - pulses[k-1], want);
            end
        end
        check_pkts(name);
        auto_mode = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        checks++; if (runnable !== 1'b0)      begin errors++; $display("FAIL reset_runnable got %b want 0", runnable); end
        checks++; if (net_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", net_out_valid); end
        checks++; if (net_out_pkt !== '0)     begin errors++; $display("FAIL reset_pkt got %h want 0", net_out_pkt); end
        checks++; if (nanci_result !== '0)    begin errors++; $display("FAIL reset_result got %h want 0", nanci_result); end
        checks++; if (err_stray !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", err_stray); end
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (pulses.size() != 0)     begin errors++; $display("FAIL idle_no_pulse got %0d want 0", pulses.size()); end
        last_result = '0;
    endtask

    task automatic test_write_loop();
        fixed_req = {1'b1, 4'd12, 32'd3};
        run_writes(5, 6, 2, "wloop");
        checks++;
        if (got.size() == 0 || got[0] !== {4'd3, 1'b1, 4'd12, 32'd3}) begin
            errors++;
            $display("FAIL wloop_first_pkt got %h want %h", (got.size() == 0) ? '0 : got[0], {4'd3, 1'b1, 4'd12, 32'd3});
        end
    endtask

    task automatic test_compute_zero();
        run_writes(0, 5, 1, "cc0");
    endtask

    task automatic test_random_writes();
        for (int r = 0; r < 4; r++) run_writes(int'($urandom_range(1, 9)), 4, 1, "rand");
    endtask

    task automatic test_backpressure();
        flush();
        compute_cycles = 14'd2;
        auto_mode = 1;
        net_out_ready = 1'b0;
        enable = 1'b1;
        repeat (60) tick();
        checks++; if (pulses.size() != 5)     begin errors++; $display("FAIL bp_stall_pulses got %0d want 5", pulses.size()); end
        checks++; if (got.size() != 0)        begin errors++; $display("FAIL bp_no_pop got %0d want 0", got.size()); end
        checks++; if (net_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", net_out_valid); end
        net_out_ready = 1'b1;
        repeat (25) tick();
        enable = 1'b0;
        repeat (30) tick();
        checks++; if (pulses.size() <= 5)     begin errors++; $display("FAIL bp_resume pulses %0d want >5", pulses.size()); end
        check_pkts("bp");
        auto_mode = 0;
    endtask

    task automatic test_read();
        logic [W:0] rd_req;
        logic [W:0] wr_req;
        logic [W:0] resp;
        int n;
        flush();
        auto_mode = 0;
        compute_cycles = 14'($urandom_range(1, 6));
        net_out_ready = 1'b1;
        rd_req = {1'b0, 4'd7, 32'd0};
        resp = {1'b0, 4'd7, 32'hDEADBEEF};
        app_request = rd_req;
        exp_q.push_back({SRC, rd_req});
        enable = 1'b1;
        n = 0;
        while (got.size() < 1 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (got.size() < 1) begin errors++; $display("FAIL rd_issue_timeout got %0d want 1", got.size()); end
        repeat (9) tick();
        checks++; if (pulses.size() != 1)        begin errors++; $display("FAIL rd_waiting pulses %0d want 1", pulses.size()); end
        checks++; if (nanci_result !== last_result) begin errors++; $display("FAIL rd_result_hold got %h want %h", nanci_result, last_result); end
        net_in_pkt = resp;
        net_in_valid = 1'b1;
        tick();
        net_in_valid = 1'b0;
        net_in_pkt = '0;
        checks++; if (nanci_result !== resp) begin errors++; $display("FAIL rd_result got %h want %h", nanci_result, resp); end
        checks++; if (runnable !== 1'b1)     begin errors++; $display("FAIL rd_runnable got %b want 1", runnable); end
        checks++; if (err_stray !== 1'b0)    begin errors++; $display("FAIL rd_err got %b want 0", err_stray); end
        last_result = resp;
        wr_req = {1'b1, 4'($urandom), 32'($urandom)};
        app_request = wr_req;
        exp_q.push_back({SRC, wr_req});
        enable = 1'b0;
        repeat (30) tick();
        check_pkts("rd");
    endtask

    task automatic test_stray();
        int n;
        flush();
        auto_mode = 1;
        compute_cycles = 14'd6;
        net_out_ready = 1'b1;
        enable = 1'b1;
        n = 0;
        while (pulses.size() < 1 && n < 50) begin tick(); n++; end
        repeat (2) tick();
        net_in_pkt = {1'b0, 4'($urandom), 32'($urandom)};
        net_in_valid = 1'b1;
        tick();
        net_in_valid = 1'b0;
        checks++; if (err_stray !== 1'b1)           begin errors++; $display("FAIL stray_err got %b want 1", err_stray); end
        checks++; if (nanci_result !== last_result) begin errors++; $display("FAIL stray_result got %h want %h", nanci_result, last_result); end
        n = 0;
        while (pulses.size() < 3 && n < 100) begin tick(); n++; end
        enable = 1'b0;
        repeat (30) tick();
        checks++; if (pulses.size() != 3) begin errors++; $display("FAIL stray_pulses got %0d want 3", pulses.size()); end
        for (int k = 1; k < pulses.size(); k++) begin
            checks++;
            if (pulses[k] - pulses[k-1] != 8) begin
                errors++;
                $display("FAIL stray_interval[%0d] got %0d want 8", k, pulses[k] - pulses[k-1]);
            end
        end
        check_pkts("stray");
        checks++; if (err_stray !== 1'b1) begin errors++; $display("FAIL stray_sticky got %b want 1", err_stray); end
        auto_mode = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        flush();
        auto_mode = 1;
        compute_cycles = 14'd10;
        net_out_ready = 1'b0;
        enable = 1'b1;
        n = 0;
        while (pulses.size() < 3 && n < 100) begin tick(); n++; end
        repeat (3) tick();
        checks++; if (net_out_valid !== 1'b1) begin errors++; $display("FAIL rm_queued got %b want 1", net_out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (runnable !== 1'b0)      begin errors++; $display("FAIL rm_runnable got %b want 0", runnable); end
        checks++; if (net_out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b want 0", net_out_valid); end
        checks++; if (net_out_pkt !== '0)     begin errors++; $display("FAIL rm_pkt got %h want 0", net_out_pkt); end
        checks++; if (nanci_result !== '0)    begin errors++; $display("FAIL rm_result got %h want 0", nanci_result); end
        checks++; if (err_stray !== 1'b0)     begin errors++; $display("FAIL rm_err got %b want 0", err_stray); end
        enable = 1'b0;
        auto_mode = 0;
        net_out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        last_result = '0;
        repeat (2) tick();
        checks++; if (net_out_valid !== 1'b0) begin errors++; $display("FAIL rm_fifo_empty got %b want 0", net_out_valid); end
        run_writes(3, 3, 1, "post_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_loop();
        test_compute_zero();
        test_random_writes();
        test_backpressure();
        test_read();
        test_stray();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nanci_app_port.md
NANCI_APP_PORT -- requirements
Module: nanci_app_port

Interface
REQ-001 Parameters: N default 1024, network node count; I default 0, this node's index; DATA_WIDTH default 32, payload width; FIFO_DEPTH default 4, outbound queue depth (power of two, >=2).
REQ-002 Derived: ADDR_WIDTH = 10/8/6/4/2 for N = 1024/256/64/16/4, else 2; WIDTH = ADDR_WIDTH+DATA_WIDTH; PKT_WIDTH = ADDR_WIDTH+WIDTH+1.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 enable  in  1  node may start new application iterations.
REQ-006 runnable  out  1  one-cycle pulse to the application; application samples its request on this edge.
REQ-007 app_request  in  WIDTH+1  {write flag, dest addr[ADDR_WIDTH], data[DATA_WIDTH]} from application.
REQ-008 compute_cycles  in  14  application compute latency.
REQ-009 nanci_result  out  WIDTH+1  last read response to the application.
REQ-010 net_out_valid / net_out_ready  out / in  1 / 1  outbound handshake.
REQ-011 net_out_pkt  out  PKT_WIDTH  {src I[ADDR_WIDTH], app_request}.
REQ-012 net_in_valid  in  1  inbound response strobe, no backpressure.
REQ-013 net_in_pkt  in  WIDTH+1  inbound response.
REQ-014 err_stray  out  1  sticky: response arrived outside WAIT_RESP.

Function
REQ-015 FSM states IDLE, RUN, COMPUTE, ISSUE, WAIT_RESP.
REQ-016 IDLE -> RUN when enable=1; runnable=1 only during RUN (exactly one cycle).
REQ-017 RUN -> COMPUTE; counter loads max(compute_cycles,1); COMPUTE lasts exactly that many cycles, then -> ISSUE.
REQ-018 ISSUE: if FIFO not full, push {I, app_request}; else stay in ISSUE (stall), no push, runnable held low.
REQ-019 After push: write flag=1 -> RUN if enable else IDLE; write flag=0 -> WAIT_RESP.
REQ-020 WAIT_RESP: on net_in_valid capture net_in_pkt into nanci_result (visible next cycle), then -> RUN if enable else IDLE.
REQ-021 Write iteration length = 2 + max(compute_cycles,1) cycles when FIFO never full.
REQ-022 enable deassertion mid-iteration: current iteration completes (including response), then IDLE.
REQ-023 FIFO: registered, first-word-fall-through; net_out_valid = not empty; pop when net_out_valid & net_out_ready; order preserved.
REQ-024 Push into empty FIFO: net_out_valid high next cycle. Simultaneous push+pop: occupancy unchanged; push while full is impossible (gated by REQ-018); pointers wrap modulo FIFO_DEPTH.
REQ-025 net_in_valid in any state except WAIT_RESP: response dropped, nanci_result unchanged, err_stray set to 1.

Reset
REQ-026 On rst: state IDLE, counter 0, FIFO empty; runnable=0, net_out_valid=0, net_out_pkt=0, nanci_result=0, err_stray=0; applies immediately regardless of clk, including mid-COMPUTE/WAIT_RESP.
REQ-027 err_stray clears only by reset.

Structure
REQ-028 Shared package nanci_pkg holds the ADDR_WIDTH(N) function, the WIDTH/PKT_WIDTH derivations, the request bit-field positions and the FSM state encoding.
REQ-029 FIFO is sub-module nanci_fifo (params WIDTH, DEPTH; ports clk, rst, push, din, pop, dout, full, empty).

Verification (N=16, I=3, DATA_WIDTH=32, FIFO_DEPTH=4)
REQ-030 Write loop: enable=1, ready=1, compute_cycles=5, app_request={1,4'd12,32'd3} -> runnable pulses every 7 cycles; each net_out_pkt = {4'd3,1'b1,4'd12,32'd3}.
REQ-031 Backpressure: ready=0 -> exactly 4 packets queued, FSM stalls in ISSUE, no further runnable; ready=1 -> 4 packets drain in order, then loop resumes.
REQ-032 Read: app_request={0,4'd7,32'd0}; net_in_valid with {0,4'd7,32'hDEADBEEF} 10 cycles after issue -> nanci_result equals it next cycle, runnable pulses the following cycle.
REQ-033 Stray: net_in_valid during COMPUTE -> err_stray=1, nanci_result unchanged, FSM unaffected.
REQ-034 Reset mid-COMPUTE with 2 queued packets -> all outputs 0 asynchronously, FIFO empty, restart from IDLE.
REQ-035 compute_cycles=0 -> write iteration length 3 cycles.
